sdram_write: RTL and testbench

- SDRAM write-burst engine; sits under the SDRAM top-level arbiter beside the init and auto-refresh engines.
- On a write trigger it raises a request to the arbiter. Once granted, it issues ACTIVE, a series of BL=4 WRITE bursts, then PRECHARGE.
- Write data is pulled from an upstream show-ahead FIFO.
- It yields to a pending refresh at burst boundaries and resumes afterwards.

---
 rtl/sdram_write_pkg.sv | 39 +++
 rtl/sdram_write.sv | 229 ++++++++++++++++++++++
 tb/tb_sdram_write.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_write_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_write_pkg
// Brief    : Shared SDRAM constants: command encodings, address/bus widths
//            and the one-hot state codes of the write-burst engine.
// Revision : 1.0 - initial release
// ============================================================================
package sdram_write_pkg;

    // Bus widths shared by the init, refresh, read and write engines
    localparam int c_ADDR_W = 12;
    localparam int c_BANK_W = 2;
    localparam int c_DQ_W   = 16;
    localparam int c_CMD_W  = 4;
    localparam int c_ROW_W  = 12;
    localparam int c_COL_W  = 8;

    // A10 selects auto-precharge on WRITE and all-bank on PRECHARGE
    localparam int c_A10 = 10;
    localparam logic [c_ADDR_W-1:0] c_ADDR_PRE_ALL = 12'h400;

    // Commands as {cs_n, ras_n, cas_n, we_n}
    localparam logic [c_CMD_W-1:0] c_CMD_NOP = 4'b0111;
    localparam logic [c_CMD_W-1:0] c_CMD_ACT = 4'b0011;
    localparam logic [c_CMD_W-1:0] c_CMD_WR  = 4'b0100;
    localparam logic [c_CMD_W-1:0] c_CMD_PRE = 4'b0010;

    // One-hot write-engine states
    localparam int c_ST_W = 6;
    typedef logic [c_ST_W-1:0] wr_state_t;
    localparam wr_state_t c_ST_IDLE = 6'b000001;
    localparam wr_state_t c_ST_ACT  = 6'b000010;
    localparam wr_state_t c_ST_TRCD = 6'b000100;
    localparam wr_state_t c_ST_WR   = 6'b001000;
    localparam wr_state_t c_ST_PRE  = 6'b010000;
    localparam wr_state_t c_ST_TRP  = 6'b100000;

endpackage
`default_nettype wire

// File: rtl/sdram_write.sv
`default_nettype none
// ============================================================================
// Module   : sdram_write
// Brief    : SDRAM write-burst engine. Requests the bus on a trigger, then
//            ACTIVE -> back-to-back BL WRITE bursts -> PRECHARGE, pulling data
//            from a show-ahead FIFO. Yields to refresh and row ends at burst
//            boundaries and resumes from the saved row/column.
//            T_RCD and T_RP must be at least 2.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_write
    import sdram_write_pkg::*;
#(
    parameter int BURST_LEN    = 4,
    parameter int T_RCD        = 2,
    parameter int T_RP         = 2,
    parameter int TOTAL_BURSTS = 8,
    parameter int COL_W        = c_COL_W,
    parameter int ROW_W        = c_ROW_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_trig_i,
    input  logic                wr_en_i,
    input  logic                ref_req_i,
    output logic                wr_req_o,
    output logic                flag_wr_end_o,
    output logic [c_CMD_W-1:0]  wr_cmd_o,
    output logic [c_ADDR_W-1:0] wr_addr_o,
    output logic [c_BANK_W-1:0] wr_bank_o,
    output logic [c_DQ_W-1:0]   wr_dq_o,
    output logic                wr_dq_oe_o,
    output logic                wr_data_req_o,
    input  logic [c_DQ_W-1:0]   wr_data_i
);

    // Shared wait counter covers tRCD, tRP and the beat index
    localparam int c_CNT_MAX = (BURST_LEN > T_RCD) ?
                               ((BURST_LEN > T_RP) ? BURST_LEN : T_RP) :
                               ((T_RCD > T_RP) ? T_RCD : T_RP);
    localparam int c_CNT_W  = $clog2(c_CNT_MAX + 1);
    localparam int c_BCNT_W = $clog2(TOTAL_BURSTS + 1);

    localparam logic [c_CNT_W-1:0]  c_BEAT_LAST = c_CNT_W'(BURST_LEN - 1);
    localparam logic [c_CNT_W-1:0]  c_TRCD_LAST = c_CNT_W'(T_RCD - 2);
    localparam logic [c_CNT_W-1:0]  c_TRP_LAST  = c_CNT_W'(T_RP - 2);
    localparam logic [c_BCNT_W-1:0] c_BURSTS    = c_BCNT_W'(TOTAL_BURSTS);
    localparam logic [COL_W-1:0]    c_COL_STEP  = COL_W'(BURST_LEN);

    wr_state_t              state_q, state_d;
    logic [c_CNT_W-1:0]     cnt_q, cnt_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [c_BCNT_W-1:0]    burst_q, burst_d;
    logic                   job_q, job_d;

    logic [c_CMD_W-1:0]     cmd_q, cmd_d;
    logic [c_ADDR_W-1:0]    addr_q, addr_d;
    logic [c_BANK_W-1:0]    bank_q, bank_d;
    logic [c_DQ_W-1:0]      dq_q, dq_d;
    logic                   oe_q, oe_d;
    logic                   flag_q, flag_d;

    logic                   w_last_beat;
    logic [COL_W-1:0]       w_col_next;
    logic                   w_col_wrap;
    logic [c_BCNT_W-1:0]    w_burst_next;
    logic                   w_job_full;
    logic                   w_trp_done;
    logic                   w_data_req;

    assign w_last_beat  = (state_q == c_ST_WR) && (cnt_q == c_BEAT_LAST);
    assign w_col_next   = col_q + c_COL_STEP;
    assign w_col_wrap   = (w_col_next == '0);
    assign w_burst_next = burst_q + c_BCNT_W'(1);
    assign w_job_full   = (w_burst_next == c_BURSTS);
    assign w_trp_done   = (state_q == c_ST_TRP) && (cnt_q == c_TRP_LAST);

    // State, datapath counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_ST_IDLE;
            cnt_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            burst_q <= '0;
            job_q   <= 1'b0;
            cmd_q   <= c_CMD_NOP;
            addr_q  <= '0;
            bank_q  <= '0;
            dq_q    <= '0;
            oe_q    <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
            burst_q <= burst_d;
            job_q   <= job_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            bank_q  <= bank_d;
            dq_q    <= dq_d;
            oe_q    <= oe_d;
            flag_q  <= flag_d;
        end
    end

    // Next state plus job/address/burst bookkeeping
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        row_d   = row_q;
        burst_d = burst_q;
        job_d   = job_q;

        // A trigger only counts when idle with nothing pending
        if ((state_q == c_ST_IDLE) && !job_q && wr_trig_i) begin
            job_d = 1'b1;
        end

        case (state_q)
            c_ST_IDLE: begin
                cnt_d = '0;
                if (job_q && wr_en_i) begin
                    state_d = c_ST_ACT;
                end
            end
            c_ST_ACT: begin
                state_d = c_ST_TRCD;
                cnt_d   = '0;
            end
            c_ST_TRCD: begin
                if (cnt_q == c_TRCD_LAST) begin
                    state_d = c_ST_WR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            c_ST_WR: begin
                if (w_last_beat) begin
                    // Burst boundary: the only place the access may end
                    cnt_d   = '0;
                    col_d   = w_col_next;
                    burst_d = w_burst_next;
                    if (w_col_wrap) begin
                        row_d = row_q + ROW_W'(1);
                    end
                    if (w_job_full || ref_req_i || w_col_wrap) begin
                        state_d = c_ST_PRE;
                    end
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            c_ST_PRE: begin
                state_d = c_ST_TRP;
                cnt_d   = '0;
            end
            c_ST_TRP: begin
                if (w_trp_done) begin
                    state_d = c_ST_IDLE;
                    cnt_d   = '0;
                    // Only a finished job releases the request
                    if (burst_q == c_BURSTS) begin
                        job_d   = 1'b0;
                        burst_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            default: begin
                state_d = c_ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so registered outputs line up with it
    always_comb begin
        cmd_d      = c_CMD_NOP;
        addr_d     = addr_q;
        bank_d     = '0;
        dq_d       = dq_q;
        oe_d       = 1'b0;
        flag_d     = w_trp_done;
        w_data_req = 1'b0;

        case (state_d)
            c_ST_ACT: begin
                cmd_d  = c_CMD_ACT;
                addr_d = c_ADDR_W'(row_q);
            end
            c_ST_WR: begin
                // Show-ahead FIFO: the beat is pulled and registered in one go
                oe_d       = 1'b1;
                w_data_req = !rst;
                dq_d       = wr_data_i;
                if (cnt_d == '0) begin
                    cmd_d         = c_CMD_WR;
                    addr_d        = c_ADDR_W'(col_d);
                    addr_d[c_A10] = 1'b0;
                end
            end
            c_ST_PRE: begin
                cmd_d  = c_CMD_PRE;
                addr_d = c_ADDR_PRE_ALL;
            end
            default: begin
                cmd_d = c_CMD_NOP;
            end
        endcase
    end

    assign wr_req_o      = job_q;
    assign flag_wr_end_o = flag_q;
    assign wr_cmd_o      = cmd_q;
    assign wr_addr_o     = addr_q;
    assign wr_bank_o     = bank_q;
    assign wr_dq_o       = dq_q;
    assign wr_dq_oe_o    = oe_q;
    assign wr_data_req_o = w_data_req;

endmodule
`default_nettype wire

// File: tb/tb_sdram_write.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_write
// Brief    : Randomized scoreboard bench for sdram_write. Two instances run
//            side by side: the default 8-burst job, and a 7-burst job whose
//            column progress crosses a row end in the middle of a job.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_write;
    import sdram_write_pkg::*;

    typedef struct {
        int          cyc;
        logic [3:0]  cmd;
        logic [11:0] addr;
        logic        flag;
        logic        req;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [15:0] fifo_mem [0:4095];
    initial for (int i = 0; i < 4096; i++) fifo_mem[i] = 16'($urandom);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input int c, input logic [3:0] cm, input logic [11:0] a,
                                input logic f, input logic r);
        exp_t e;
        e.cyc = c; e.cmd = cm; e.addr = a; e.flag = f; e.req = r;
        return e;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int TB = (gi == 0) ? 8 : 7;

        logic        rst, wr_trig, wr_en, ref_req;
        logic        wr_req, flag, oe, dreq;
        logic [3:0]  cmd;
        logic [11:0] addr;
        logic [1:0]  bank;
        logic [15:0] dq, wr_data;
        int          rd_ptr = 0;
        int          dreq_cnt = 0;
        logic [15:0] prev_data = '0;
        bit          fin = 1'b0;
        exp_t        cq[$];
        logic [15:0] dqq[$];

        // Show-ahead FIFO: head word visible, popped by the read strobe
        assign wr_data = fifo_mem[rd_ptr % 4096];
        always @(posedge clk) if (dreq) rd_ptr <= rd_ptr + 1;

        sdram_write #(.TOTAL_BURSTS(TB)) u_dut (
            .clk           (clk),
            .rst           (rst),
            .wr_trig_i     (wr_trig),
            .wr_en_i       (wr_en),
            .ref_req_i     (ref_req),
            .wr_req_o      (wr_req),
            .flag_wr_end_o (flag),
            .wr_cmd_o      (cmd),
            .wr_addr_o     (addr),
            .wr_bank_o     (bank),
            .wr_dq_o       (dq),
            .wr_dq_oe_o    (oe),
            .wr_data_req_o (dreq),
            .wr_data_i     (wr_data)
        );

        // Monitor: pop the expected event whenever the DUT shows a command, flag or beat
        always @(negedge clk) begin
            exp_t e;
            if (rst) dreq_cnt = 0;
            else if (dreq) dreq_cnt++;
            if (flag || cmd != c_CMD_NOP) begin
                if (cq.size() == 0) begin
                    check("unexpected_output", {27'd0, flag, cmd}, {27'd0, 1'b0, c_CMD_NOP});
                end else begin
                    e = cq.pop_front();
                    check("event_cycle", cyc, e.cyc);
                    check("event_cmd_flag", {27'd0, flag, cmd}, {27'd0, e.flag, e.cmd});
                    if (e.flag) begin
                        check("wr_req_at_end", {31'd0, wr_req}, {31'd0, e.req});
                        if (!e.req) begin
                            check("data_req_per_job", dreq_cnt, 4 * TB);
                            dreq_cnt = 0;
                        end
                    end else begin
                        check("cmd_addr", {20'd0, addr}, {20'd0, e.addr});
                        if (e.cmd != c_CMD_PRE) check("cmd_bank", {30'd0, bank}, 32'd0);
                    end
                end
            end
            if (oe) begin
                check("dq_follows_fifo", {16'd0, dq}, {16'd0, prev_data});
                if (dqq.size() == 0) check("unexpected_beat", {31'd0, oe}, 32'd0);
                else check("dq_data", {16'd0, dq}, {16'd0, dqq.pop_front()});
            end
            prev_data = wr_data;
        end

        // Stimulus + job-level reference model
        initial begin
            int row, col, rem, nb, nb0, kref, g, r, m, f, spur;
            bit use_ref, co_trig;
            rst = 1'b1; wr_trig = 1'b0; wr_en = 1'b0; ref_req = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            @(negedge clk);
            check("rst_cmd", {28'd0, cmd}, 32'h7);
            check("rst_addr", {20'd0, addr}, 32'd0);
            check("rst_bank", {30'd0, bank}, 32'd0);
            check("rst_dq", {16'd0, dq}, 32'd0);
            check("rst_ctrl", {28'd0, oe, wr_req, flag, dreq}, 32'd0);
            @(posedge clk); #1;
            rst = 1'b0;

            // Grant without a pending job must be ignored
            wr_en = 1'b1;
            @(posedge clk); #1;
            wr_en = 1'b0;
            repeat (6) begin @(posedge clk); #1; end

            row = 0; col = 0; m = rd_ptr;
            for (int j = 0; j < 12; j++) begin
                wr_trig = 1'b1;
                @(posedge clk); #1;
                wr_trig = 1'b0;
                check("req_after_trig", {31'd0, wr_req}, 32'd1);
                repeat (2) begin @(posedge clk); #1; end
                rem = TB;
                while (rem > 0) begin
                    g = cyc;
                    wr_en = 1'b1;
                    nb0 = ((256 - col) / 4 < rem) ? (256 - col) / 4 : rem;
                    use_ref = ($urandom_range(0, 2) == 0);
                    r = g + int'($urandom_range(1, 4 * nb0 + 6));
                    nb = nb0;
                    if (use_ref) begin
                        // Refresh is honoured at the first burst whose last beat is at or after r
                        kref = (r <= g + 6) ? 1 : (r - g - 6 + 3) / 4 + 1;
                        if (kref < nb) nb = kref;
                    end
                    cq.push_back(mk(g + 1, c_CMD_ACT, 12'(row), 1'b0, 1'b0));
                    for (int k = 0; k < nb; k++) begin
                        cq.push_back(mk(g + 3 + 4 * k, c_CMD_WR, 12'(col + 4 * k), 1'b0, 1'b0));
                        for (int b = 0; b < 4; b++) begin
                            dqq.push_back(fifo_mem[m % 4096]);
                            m++;
                        end
                    end
                    cq.push_back(mk(g + 3 + 4 * nb, c_CMD_PRE, 12'h400, 1'b0, 1'b0));
                    f = g + 5 + 4 * nb;
                    cq.push_back(mk(f, c_CMD_NOP, 12'd0, 1'b1, (rem > nb)));
                    co_trig = (rem == nb) && ($urandom_range(0, 1) == 1);
                    spur = g + int'($urandom_range(1, 4 * nb + 3));
                    do begin
                        @(posedge clk); #1;
                        wr_en   = 1'b0;
                        ref_req = use_ref && (cyc >= r);
                        wr_trig = (cyc == spur) || (co_trig && cyc == f - 1);
                    end while (cyc < f);
                    ref_req = 1'b0;
                    wr_trig = 1'b0;
                    if (col + 4 * nb >= 256) row = (row + 1) % 4096;
                    col = (col + 4 * nb) % 256;
                    rem = rem - nb;
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                end
                if ($urandom_range(0, 1) == 1) begin
                    wr_en = 1'b1;
                    @(posedge clk); #1;
                    wr_en = 1'b0;
                end
            end

            // Reset during beat 2 of the first burst
            wr_trig = 1'b1;
            @(posedge clk); #1;
            wr_trig = 1'b0;
            g = cyc;
            wr_en = 1'b1;
            cq.push_back(mk(g + 1, c_CMD_ACT, 12'(row), 1'b0, 1'b0));
            cq.push_back(mk(g + 3, c_CMD_WR, 12'(col), 1'b0, 1'b0));
            for (int b = 0; b < 3; b++) dqq.push_back(fifo_mem[(m + b) % 4096]);
            @(posedge clk); #1;
            wr_en = 1'b0;
            while (cyc < g + 5) begin @(posedge clk); #1; end
            rst = 1'b1;
            @(posedge clk); #1;
            check("mid_rst_cmd", {28'd0, cmd}, 32'h7);
            check("mid_rst_oe_req", {30'd0, oe, wr_req}, 32'd0);
            rst = 1'b0;
            m = rd_ptr; row = 0; col = 0;
            repeat (2) begin @(posedge clk); #1; end
            wr_en = 1'b1;
            @(posedge clk); #1;
            wr_en = 1'b0;
            repeat (12) begin @(posedge clk); #1; end
            check("scoreboard_drained", cq.size() + dqq.size(), 32'd0);
            fin = 1'b1;
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(g_inst[0].fin && g_inst[1].fin) && n < 60000) begin
            @(posedge clk);
            n++;
        end
        check("both_runs_finished", {30'd0, g_inst[0].fin, g_inst[1].fin}, 32'd3);
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
